// File: rtl/resp_ram_dma_wr.sv
// resp_ram_dma_wr: write-side result DMA. Accepts 32-bit result words over a
// valid/ready handshake, buffers them in a small word FIFO and writes each word
// little-endian, one byte per SRAM write cycle, starting at a configured base address.
module resp_ram_dma_wr #(
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int WORD_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int WE_PULSE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_start,
    input  logic [RAM_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [RAM_ADDR_WIDTH-3:0] cfg_num_words,
    input  logic                      resp_vld,
    input  logic [WORD_WIDTH-1:0]     resp_data,
    output logic                      resp_ready,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [7:0]                ram_wr_data,
    output logic                      CE_bar,
    output logic                      OE_bar,
    output logic                      WE_bar,
    output logic                      busy,
    output logic                      wr_done,
    output logic                      cfg_err
);

    localparam int CNT_W  = RAM_ADDR_WIDTH - 2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int PCNT_W = (WE_PULSE_CYCLES > 1) ? $clog2(WE_PULSE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ARM, SETUP, PULSE, HOLD, DONE} state_t;

    state_t                    state, state_nxt;

    logic [WORD_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [PTR_W:0]            fifo_cnt;
    logic                      fifo_full, fifo_empty, push, pop;

    logic [CNT_W-1:0]          num_words, accepted, written;
    logic [RAM_ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0]     word_q;
    logic [1:0]                byte_idx;
    logic [PCNT_W-1:0]         pulse_cnt;
    logic                      start_ok, last_byte, pulse_last;

    // The full flag comes straight from the registered count, so a pop in the
    // same cycle never lets a new word in until the following cycle.
    assign fifo_full   = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty  = (fifo_cnt == '0);
    assign resp_ready  = busy & ~fifo_full & (accepted < num_words);
    assign push        = resp_vld & resp_ready;
    assign pop         = (state == ARM) & ~fifo_empty;
    assign start_ok    = cfg_start & (state == IDLE);
    assign last_byte   = (byte_idx == 2'd3);
    assign pulse_last  = (pulse_cnt == PCNT_W'(WE_PULSE_CYCLES - 1));

    assign OE_bar      = 1'b1;
    assign ram_wr_addr = addr;
    assign ram_wr_data = word_q[{byte_idx, 3'b000} +: 8];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of block order.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and SRAM strobes; strobes decode from state so reset releases them at once.
    always_comb begin
        // NOTE: every output gets a default first; a path that leaves one
        // unassigned would infer a latch.
        state_nxt = state;
        CE_bar    = 1'b1;
        WE_bar    = 1'b1;
        case (state)
            IDLE:  if (cfg_start) state_nxt = (cfg_num_words == '0) ? DONE : ARM;
            ARM:   if (!fifo_empty) state_nxt = SETUP;
            SETUP: begin
                CE_bar    = 1'b0;
                state_nxt = PULSE;
            end
            PULSE: begin
                CE_bar = 1'b0;
                WE_bar = 1'b0;
                if (pulse_last) state_nxt = HOLD;
            end
            HOLD: begin
                CE_bar = 1'b0;
                if (!last_byte)                                 state_nxt = SETUP;
                else if (written + CNT_W'(1) == num_words)      state_nxt = DONE;
                else                                            state_nxt = ARM;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Batch control, status pulses and the byte serialiser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            wr_done   <= 1'b0;
            cfg_err   <= 1'b0;
            num_words <= '0;
            accepted  <= '0;
            written   <= '0;
            addr      <= '0;
            word_q    <= '0;
            byte_idx  <= '0;
            pulse_cnt <= '0;
        end else begin
            wr_done <= (state == DONE);
            cfg_err <= cfg_start & busy;

            if (start_ok) begin
                busy      <= 1'b1;
                num_words <= cfg_num_words;
                addr      <= cfg_base_addr;
                accepted  <= '0;
                written   <= '0;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end

            if (push) accepted <= accepted + CNT_W'(1);

            if (pop) begin
                word_q   <= fifo_mem[rd_ptr];
                byte_idx <= '0;
            end

            if (state == SETUP)      pulse_cnt <= '0;
            else if (state == PULSE) pulse_cnt <= pulse_cnt + PCNT_W'(1);

            // byte_idx stays on the last byte after a word so the data bus holds.
            if (state == HOLD) begin
                addr <= addr + RAM_ADDR_WIDTH'(1);
                if (!last_byte) byte_idx <= byte_idx + 2'd1;
                else            written  <= written + CNT_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers and count define
        // which entries are valid, so clearing the array would only cost logic.
        if (push) fifo_mem[wr_ptr] <= resp_data;
    end

endmodule

// File: tb/tb_resp_ram_dma_wr.sv
// Testbench for resp_ram_dma_wr: drives batches, predicts every SRAM byte write
// into a scoreboard queue and compares against writes captured from the SRAM strobes.
module tb_resp_ram_dma_wr;

    localparam int PULSE = 2;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          len;
        bit          stable;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_base_addr = '0;
    logic [13:0] cfg_num_words = '0;
    logic        resp_vld = 1'b0;
    logic [31:0] resp_data = '0;
    logic        resp_ready;
    logic [15:0] ram_wr_addr;
    logic [7:0]  ram_wr_data;
    logic        CE_bar, OE_bar, WE_bar, busy, wr_done, cfg_err;

    int total = 0;
    int bad = 0;

    exp_t        exp_q[$];
    obs_t        obs_q[$];
    logic [31:0] stim_q[$];

    // monitor state
    bit          in_pulse = 0;
    logic [15:0] p_addr = '0;
    logic [7:0]  p_data = '0;
    int          p_len = 0;
    bit          p_stable = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          ce_low_cnt = 0;

    resp_ram_dma_wr #(
        .RAM_ADDR_WIDTH(16), .WORD_WIDTH(32), .FIFO_DEPTH(4), .WE_PULSE_CYCLES(PULSE)
    ) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_num_words(cfg_num_words), .resp_vld(resp_vld), .resp_data(resp_data),
        .resp_ready(resp_ready), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .CE_bar(CE_bar), .OE_bar(OE_bar), .WE_bar(WE_bar), .busy(busy),
        .wr_done(wr_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Capture each WE_bar low pulse as one byte write (address, data, length, stability).
    always @(negedge clk) begin
        if (reset) begin
            in_pulse = 0;
        end else begin
            if (!CE_bar)  ce_low_cnt++;
            if (wr_done)  done_cnt++;
            if (cfg_err)  err_cnt++;
            if (!WE_bar) begin
                if (!in_pulse) begin
                    in_pulse = 1;
                    p_addr   = ram_wr_addr;
                    p_data   = ram_wr_data;
                    p_len    = 1;
                    p_stable = !CE_bar;
                end else begin
                    p_len++;
                    if (ram_wr_addr !== p_addr || ram_wr_data !== p_data || CE_bar !== 1'b0)
                        p_stable = 0;
                end
            end else if (in_pulse) begin
                in_pulse = 0;
                obs_q.push_back('{addr: p_addr, data: p_data, len: p_len, stable: p_stable});
            end
        end
    end

    // Start a batch, feed stim_q with resp_vld held high, wait for wr_done.
    // Expected bytes are queued as each word is handed over.
    task automatic run_batch(input logic [15:0] base, input int n,
                             output int latency, output int extra_ready,
                             output bit stall_seen, output bit timed_out);
        int          acc;
        logic [31:0] w;
        exp_t        e;
        latency = 0; extra_ready = 0; stall_seen = 0; timed_out = 0; acc = 0;
        @(posedge clk); #1;
        cfg_base_addr = base;
        cfg_num_words = 14'(n);
        cfg_start     = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        resp_vld  = 1'b1;
        resp_data = (n > 0) ? stim_q[0] : 32'hBAD0_BAD0;
        while (1) begin
            @(negedge clk);
            latency++;
            if (wr_done) break;
            if (latency > 3000) begin timed_out = 1; break; end
            if (busy && acc < n && !resp_ready) stall_seen = 1;
            if (resp_ready && acc >= n) extra_ready++;
            if (resp_ready && acc < n) begin
                w = stim_q[acc];
                for (int k = 0; k < 4; k++) begin
                    e.addr = base + 16'(4 * acc + k);
                    e.data = w[8*k +: 8];
                    exp_q.push_back(e);
                end
                acc++;
                @(posedge clk); #1;
                resp_data = (acc < n) ? stim_q[acc] : 32'hBAD0_BAD0;
            end
        end
        resp_vld = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({CE_bar, OE_bar, WE_bar, busy, wr_done, cfg_err, resp_ready} !== 7'b1110000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 1110000",
                     {CE_bar, OE_bar, WE_bar, busy, wr_done, cfg_err, resp_ready});
        end
        total++;
        if (ram_wr_addr !== 16'h0000) begin
            bad++; $display("FAIL reset_addr: got %h want 0000", ram_wr_addr);
        end
        total++;
        if (ram_wr_data !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %h want 00", ram_wr_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, resp_ready, CE_bar, WE_bar} !== 4'b0011) begin
            bad++; $display("FAIL idle_after_reset: got %b want 0011", {busy, resp_ready, CE_bar, WE_bar});
        end
    endtask

    task automatic test_single_word;
        int lat, xr, d0; bit st, to; obs_t o; exp_t e;
        stim_q = '{32'hDEAD_BEEF};
        d0 = done_cnt;
        run_batch(16'h0010, 1, lat, xr, st, to);
        repeat (3) @(negedge clk);
        total++;
        if (to || lat != 20) begin bad++; $display("FAIL t1_latency: got %0d timeout=%0d want 20", lat, to); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL t1_done: got %0d pulses want 1", done_cnt - d0); end
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL t1_count: got %0d writes want 4", obs_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.addr !== e.addr || o.data !== e.data || o.len != PULSE || !o.stable) begin
                bad++;
                $display("FAIL t1_byte: got %h@%h len=%0d stable=%0d want %h@%h len=%0d stable=1",
                         o.data, o.addr, o.len, o.stable, e.data, e.addr, PULSE);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_fifo_stall;
        int lat, xr, d0; bit st, to; obs_t o; exp_t e;
        stim_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        d0 = done_cnt;
        run_batch(16'h0100, 6, lat, xr, st, to);
        repeat (3) @(negedge clk);
        total++;
        if (to || lat != 105) begin bad++; $display("FAIL t2_latency: got %0d timeout=%0d want 105", lat, to); end
        total++;
        if (!st) begin bad++; $display("FAIL t2_stall: resp_ready never dropped while FIFO full"); end
        total++;
        if (xr != 0) begin bad++; $display("FAIL t2_ready_after_last: got %0d ready cycles want 0", xr); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL t2_done: got %0d pulses want 1", done_cnt - d0); end
        total++;
        if (obs_q.size() != 24) begin bad++; $display("FAIL t2_count: got %0d writes want 24", obs_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.addr !== e.addr || o.data !== e.data || o.len != PULSE || !o.stable) begin
                bad++;
                $display("FAIL t2_byte: got %h@%h len=%0d stable=%0d want %h@%h", o.data, o.addr, o.len,
                         o.stable, e.data, e.addr);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_cfg_err;
        int lat, xr, d0, e0; bit st, to; obs_t o; exp_t e;
        stim_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        d0 = done_cnt; e0 = err_cnt;
        fork
            run_batch(16'h0100, 6, lat, xr, st, to);
            begin
                repeat (30) @(posedge clk);
                #1;
                cfg_start = 1'b1; cfg_base_addr = 16'hAAAA; cfg_num_words = 14'd5;
                @(posedge clk); #1;
                cfg_start = 1'b0;
                @(negedge clk);
                total++;
                if (cfg_err !== 1'b1) begin bad++; $display("FAIL t5_err_pulse: got %b want 1", cfg_err); end
                @(negedge clk);
                total++;
                if (cfg_err !== 1'b0) begin bad++; $display("FAIL t5_err_width: got %b want 0", cfg_err); end
            end
        join
        repeat (3) @(negedge clk);
        total++;
        if (err_cnt - e0 != 1) begin bad++; $display("FAIL t5_err_count: got %0d want 1", err_cnt - e0); end
        total++;
        if (to || lat != 105 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL t5_batch: latency=%0d done=%0d want 105 and 1", lat, done_cnt - d0);
        end
        total++;
        if (obs_q.size() != 24) begin bad++; $display("FAIL t5_count: got %0d writes want 24", obs_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.addr !== e.addr || o.data !== e.data || o.len != PULSE || !o.stable) begin
                bad++;
                $display("FAIL t5_byte: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_zero_words;
        int lat, xr, d0, c0; bit st, to;
        stim_q.delete();
        d0 = done_cnt; c0 = ce_low_cnt;
        run_batch(16'h0200, 0, lat, xr, st, to);
        repeat (3) @(negedge clk);
        total++;
        if (to || lat != 2) begin bad++; $display("FAIL t3_latency: got %0d timeout=%0d want 2", lat, to); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL t3_done: got %0d pulses want 1", done_cnt - d0); end
        total++;
        if (ce_low_cnt != c0 || obs_q.size() != 0) begin
            bad++; $display("FAIL t3_no_strobe: ce_low=%0d writes=%0d want 0 and 0", ce_low_cnt - c0, obs_q.size());
        end
        total++;
        if (xr != 0) begin bad++; $display("FAIL t3_ready: got %0d ready cycles want 0", xr); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_addr_wrap;
        int lat, xr, d0; bit st, to; obs_t o; exp_t e;
        stim_q = '{32'h4433_2211};
        d0 = done_cnt;
        run_batch(16'hFFFE, 1, lat, xr, st, to);
        repeat (3) @(negedge clk);
        total++;
        if (to || lat != 20 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL t4_batch: latency=%0d done=%0d want 20 and 1", lat, done_cnt - d0);
        end
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL t4_count: got %0d writes want 4", obs_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.addr !== e.addr || o.data !== e.data || o.len != PULSE || !o.stable) begin
                bad++;
                $display("FAIL t4_byte: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_write;
        int lat, xr, d0; bit st, to, seen; obs_t o; exp_t e;
        d0 = done_cnt;
        seen = 0;
        @(posedge clk); #1;
        cfg_base_addr = 16'h0010; cfg_num_words = 14'd1; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0; resp_vld = 1'b1; resp_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !resp_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        resp_vld = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (WE_bar === 1'b0) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL t6_pulse_seen: WE_bar never went low within 100 cycles"); end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({WE_bar, CE_bar, busy} !== 3'b110) begin
            bad++; $display("FAIL t6_async_reset: got WE_bar,CE_bar,busy=%b want 110", {WE_bar, CE_bar, busy});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            bad++; $display("FAIL t6_discard: done=%0d busy=%b want 0 and 0", done_cnt - d0, busy);
        end
        obs_q.delete(); exp_q.delete();
        stim_q = '{32'hDEAD_BEEF};
        d0 = done_cnt;
        run_batch(16'h0010, 1, lat, xr, st, to);
        repeat (3) @(negedge clk);
        total++;
        if (to || lat != 20 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL t6_rerun: latency=%0d done=%0d want 20 and 1", lat, done_cnt - d0);
        end
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL t6_count: got %0d writes want 4", obs_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++;
            if (o.addr !== e.addr || o.data !== e.data || o.len != PULSE || !o.stable) begin
                bad++;
                $display("FAIL t6_byte: got %h@%h len=%0d want %h@%h len=%0d", o.data, o.addr, o.len,
                         e.data, e.addr, PULSE);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_fifo_stall;
        test_cfg_err;
        test_zero_words;
        test_addr_wrap;
        test_reset_mid_write;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
